spi_reg_slave: RTL

Parametrised SPI slave with a register-bus front end, successor to the fixed 8-bit, mode-0 SPI slave. It oversamples `sclk`, `cs` and `mosi` in the `clk` domain and supports all four CPOL/CPHA modes and a configurable word width. Each frame starts with a command word (R/W bit plus start address), then streams data words with address auto-increment. It sits between the board SPI pins and the miner's control/status register file.

---
 rtl/spi_reg_slave.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - oversampled SPI slave (all CPOL/CPHA modes) driving a register bus
module spi_reg_slave #(
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk,
    input  logic                         cs,
    input  logic                         mosi,
    output logic                         miso,
    output logic [ADDR_W-1:0]            reg_addr,
    output logic [WORD_W-1:0]            reg_wdata,
    output logic                         reg_we,
    output logic                         reg_re,
    input  logic [WORD_W-1:0]            reg_rdata,
    output logic                         busy,
    output logic [$clog2(WORD_W+1)-1:0]  bit_count,
    output logic                         frame_err
);

    localparam int BW            = $clog2(WORD_W + 1);
    localparam bit P_IDLE_LVL    = (CPOL != 0);
    localparam bit P_SAMPLE_RISE = (CPOL == CPHA);
    localparam bit P_CPHA0       = (CPHA == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_armed;
    logic [BW-1:0]          r_bit_cnt;
    logic [WORD_W-1:0]      r_shift_in;
    logic                   r_rw;
    logic [ADDR_W-1:0]      r_addr;
    logic [WORD_W-1:0]      r_wdata;
    logic                   r_we, r_re, r_re_d;
    logic                   r_frame_err;
    logic [WORD_W-1:0]      r_tx;
    logic                   r_miso;
    logic                   r_skip;

    logic                   w_sclk, w_cs, w_mosi;
    logic                   w_rise, w_fall, w_sample, w_shift;
    logic                   w_active, w_word_done;
    logic [WORD_W-1:0]      w_word;

    // cs chain resets to "selected" so a low pin after reset cannot arm the block
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sclk_sync <= {SYNC_STAGES{P_IDLE_LVL}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= P_IDLE_LVL;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk;
            if (w_cs)
                r_armed <= 1'b1;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk & ~r_sclk_prev;
    assign w_fall      = ~w_sclk & r_sclk_prev;
    assign w_sample    = P_SAMPLE_RISE ? w_rise : w_fall;
    assign w_shift     = P_SAMPLE_RISE ? w_fall : w_rise;
    assign w_active    = (r_state != ST_IDLE);
    assign w_word      = {r_shift_in[WORD_W-2:0], w_mosi};
    assign w_word_done = w_active && !w_cs && w_sample && (r_bit_cnt == BW'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_armed && !w_cs) w_state_nxt = ST_CMD;
            ST_CMD:  if (w_cs) w_state_nxt = ST_IDLE;
                     else if (w_word_done) w_state_nxt = ST_DATA;
            ST_DATA: if (w_cs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_re_d      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_frame_err <= 1'b0;
            r_re_d      <= r_re;
            if (r_we)
                r_addr <= r_addr + ADDR_W'(1);
            if (!w_active || w_cs) begin
                r_bit_cnt   <= '0;
                r_frame_err <= w_active && (r_bit_cnt != '0);
            end else if (w_sample) begin
                r_shift_in <= w_word;
                if (w_word_done) begin
                    r_bit_cnt <= '0;
                    if (r_state == ST_CMD) begin
                        r_rw   <= w_word[WORD_W-1];
                        r_addr <= w_word[ADDR_W-1:0];
                        r_re   <= w_word[WORD_W-1];
                    end else if (r_rw) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_re   <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_word;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end
        end
    end

    // CPHA=0 puts the MSB out at load and swallows the shift edge that trails the completing sample
    always_ff @(posedge clk) begin
        if (!reset || !w_active) begin
            r_tx   <= '0;
            r_miso <= 1'b0;
            r_skip <= 1'b0;
        end else if (r_re_d) begin
            if (P_CPHA0) begin
                r_miso <= reg_rdata[WORD_W-1];
                r_tx   <= {reg_rdata[WORD_W-2:0], 1'b0};
                r_skip <= 1'b1;
            end else begin
                r_tx   <= reg_rdata;
            end
        end else if (w_shift && !w_cs) begin
            if (r_skip) begin
                r_skip <= 1'b0;
            end else begin
                r_miso <= r_tx[WORD_W-1];
                r_tx   <= {r_tx[WORD_W-2:0], 1'b0};
            end
        end
    end

    assign miso      = (w_active && !w_cs) ? r_miso : 1'bz;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = w_active;
    assign bit_count = r_bit_cnt;
    assign frame_err = r_frame_err;

endmodule
